// File: rtl/axil_ram_pkg.sv
// Shared types and address decode helper for the AXI-Lite RAM responder.
package axil_ram_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_RESP = 1'b1
    } wr_state_t;

    // Full-width word index relative to the RAM base; callers slice or range-check it.
    function automatic logic [63:0] addr_to_word(input logic [63:0] addr,
                                                 input logic [63:0] base,
                                                 input int unsigned byte_shift);
        return (addr - base) >> byte_shift;
    endfunction

endpackage

// File: rtl/axil_ram_mem.sv
// Single-clock RAM: one byte-enabled write port, one registered read port, no reset.
module axil_ram_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ADDR_BITS  = 10
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_BITS-1:0]  waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [STRB_WIDTH-1:0] wstrb_i,
    input  logic                  re_i,
    input  logic [ADDR_BITS-1:0]  raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_BITS];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Read and write share one block so a same-edge collision returns the old word.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
        for (int i = 0; i < STRB_WIDTH; i++) begin
            if (we_i && wstrb_i[i]) begin
                mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axil_ram_slave.sv
// AXI-Lite responder backed by a word-addressed RAM.
// Define AXIL_RAM_OOR_ERR_EN to answer out-of-range accesses with SLVERR instead of wrapping.
module axil_ram_slave
    import axil_ram_pkg::*;
#(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    AXIL_DATA_WIDTH = 32,
    parameter int                    AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8,
    parameter int                    MEM_WORDS_LOG2  = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_WIDTH-1:0]      s_axil_awaddr,
    input  logic [2:0]                 s_axil_awprot,
    input  logic                       s_axil_awvalid,
    output logic                       s_axil_awready,
    input  logic [AXIL_DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [AXIL_STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                       s_axil_wvalid,
    output logic                       s_axil_wready,
    output logic [1:0]                 s_axil_bresp,
    output logic                       s_axil_bvalid,
    input  logic                       s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]      s_axil_araddr,
    input  logic [2:0]                 s_axil_arprot,
    input  logic                       s_axil_arvalid,
    output logic                       s_axil_arready,
    output logic [AXIL_DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]                 s_axil_rresp,
    output logic                       s_axil_rvalid,
    input  logic                       s_axil_rready
);

    localparam int unsigned BYTE_SHIFT = $clog2(AXIL_STRB_WIDTH);

    wr_state_t                  wrState_q, wrState_d;
    logic                       awFull_q, awFull_d;
    logic [ADDR_WIDTH-1:0]      awAddr_q, awAddr_d;
    logic                       wFull_q, wFull_d;
    logic [AXIL_DATA_WIDTH-1:0] wData_q, wData_d;
    logic [AXIL_STRB_WIDTH-1:0] wStrb_q, wStrb_d;
    resp_t                      bresp_q, bresp_d;
    logic                       rvalid_q, rvalid_d;
    resp_t                      rresp_q, rresp_d;
    logic                       rdZero_q, rdZero_d;

    logic                       awHs, wHs, arHs, commit;
    logic [63:0]                awWord, arWord;
    logic                       wrAllowed, rdAllowed;
    resp_t                      wrResp, rdResp;
    logic [AXIL_DATA_WIDTH-1:0] memRdata;

    assign awHs   = s_axil_awvalid && s_axil_awready;
    assign wHs    = s_axil_wvalid && s_axil_wready;
    assign arHs   = s_axil_arvalid && s_axil_arready;
    assign commit = (wrState_q == WR_IDLE) && awFull_q && wFull_q;

    assign awWord = addr_to_word(64'(awAddr_q), 64'(BASE_ADDR), BYTE_SHIFT);
    assign arWord = addr_to_word(64'(s_axil_araddr), 64'(BASE_ADDR), BYTE_SHIFT);

`ifdef AXIL_RAM_OOR_ERR_EN
    assign wrAllowed = (64'(awAddr_q) >= 64'(BASE_ADDR)) && ((awWord >> MEM_WORDS_LOG2) == 64'd0);
    assign rdAllowed = (64'(s_axil_araddr) >= 64'(BASE_ADDR)) && ((arWord >> MEM_WORDS_LOG2) == 64'd0);
    assign wrResp    = wrAllowed ? OKAY : SLVERR;
    assign rdResp    = rdAllowed ? OKAY : SLVERR;
`else
    assign wrAllowed = 1'b1;
    assign rdAllowed = 1'b1;
    assign wrResp    = OKAY;
    assign rdResp    = OKAY;
`endif

    // Holding registers fill independently; a commit can only happen while both are full,
    // and then neither side is ready, so fill and clear never collide.
    always_comb begin
        wrState_d = wrState_q;
        awFull_d  = awFull_q;
        awAddr_d  = awAddr_q;
        wFull_d   = wFull_q;
        wData_d   = wData_q;
        wStrb_d   = wStrb_q;
        bresp_d   = bresp_q;
        if (awHs) begin
            awFull_d = 1'b1;
            awAddr_d = s_axil_awaddr;
        end
        if (wHs) begin
            wFull_d = 1'b1;
            wData_d = s_axil_wdata;
            wStrb_d = s_axil_wstrb;
        end
        case (wrState_q)
            WR_IDLE: begin
                if (commit) begin
                    awFull_d  = 1'b0;
                    wFull_d   = 1'b0;
                    bresp_d   = wrResp;
                    wrState_d = WR_RESP;
                end
            end
            default: begin
                if (s_axil_bready) begin
                    bresp_d   = OKAY;
                    wrState_d = WR_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdZero_d = rdZero_q;
        if (rvalid_q && s_axil_rready) begin
            rvalid_d = 1'b0;
        end
        if (arHs) begin
            rvalid_d = 1'b1;
            rresp_d  = rdResp;
            rdZero_d = !rdAllowed;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrState_q <= WR_IDLE;
            awFull_q  <= 1'b0;
            awAddr_q  <= '0;
            wFull_q   <= 1'b0;
            wData_q   <= '0;
            wStrb_q   <= '0;
            bresp_q   <= OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= OKAY;
            rdZero_q  <= 1'b0;
        end else begin
            wrState_q <= wrState_d;
            awFull_q  <= awFull_d;
            awAddr_q  <= awAddr_d;
            wFull_q   <= wFull_d;
            wData_q   <= wData_d;
            wStrb_q   <= wStrb_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdZero_q  <= rdZero_d;
        end
    end

    axil_ram_mem #(
        .DATA_WIDTH (AXIL_DATA_WIDTH),
        .STRB_WIDTH (AXIL_STRB_WIDTH),
        .ADDR_BITS  (MEM_WORDS_LOG2)
    ) u_mem (
        .clk     (clk),
        .we_i    (commit && wrAllowed),
        .waddr_i (awWord[MEM_WORDS_LOG2-1:0]),
        .wdata_i (wData_q),
        .wstrb_i (wStrb_q),
        .re_i    (arHs),
        .raddr_i (arWord[MEM_WORDS_LOG2-1:0]),
        .rdata_o (memRdata)
    );

    // Readies are gated by rst so nothing handshakes while reset is held.
    assign s_axil_awready = !rst && !awFull_q;
    assign s_axil_wready  = !rst && !wFull_q;
    assign s_axil_bvalid  = (wrState_q == WR_RESP);
    assign s_axil_bresp   = bresp_q;
    assign s_axil_arready = !rst && (!rvalid_q || s_axil_rready);
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rresp   = rresp_q;
    assign s_axil_rdata   = (rvalid_q && !rdZero_q) ? memRdata : '0;

endmodule

// File: tb/tb_axil_ram_slave.sv
// Scoreboard bench for axil_ram_slave with a 16-word RAM; honours AXIL_RAM_OOR_ERR_EN.
module tb_axil_ram_slave;
    import axil_ram_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [16];
    logic [1:0]  expB [$];
    logic [33:0] expR [$];

    axil_ram_slave #(
        .ADDR_WIDTH      (32),
        .AXIL_DATA_WIDTH (32),
        .AXIL_STRB_WIDTH (4),
        .MEM_WORDS_LOG2  (4),
        .BASE_ADDR       (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_axil_awaddr  (awaddr),
        .s_axil_awprot  (3'b000),
        .s_axil_awvalid (awvalid),
        .s_axil_awready (awready),
        .s_axil_wdata   (wdata),
        .s_axil_wstrb   (wstrb),
        .s_axil_wvalid  (wvalid),
        .s_axil_wready  (wready),
        .s_axil_bresp   (bresp),
        .s_axil_bvalid  (bvalid),
        .s_axil_bready  (bready),
        .s_axil_araddr  (araddr),
        .s_axil_arprot  (3'b000),
        .s_axil_arvalid (arvalid),
        .s_axil_arready (arready),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp),
        .s_axil_rvalid  (rvalid),
        .s_axil_rready  (rready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                              output logic [1:0] resp);
        logic [29:0] idx;
        idx  = addr[31:2];
        resp = 2'b00;
`ifdef AXIL_RAM_OOR_ERR_EN
        if (idx >= 30'd16) begin
            resp = 2'b10;
            return;
        end
`endif
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) model[idx[3:0]][b*8 +: 8] = data[b*8 +: 8];
        end
    endtask

    task automatic modelRead(input logic [31:0] addr, output logic [33:0] e);
        logic [29:0] idx;
        idx = addr[31:2];
        e   = {2'b00, model[idx[3:0]]};
`ifdef AXIL_RAM_OOR_ERR_EN
        if (idx >= 30'd16) e = {2'b10, 32'h0};
`endif
    endtask

    // Responses are scored on the cycle before their handshake edge.
    always @(negedge clk) begin
        logic [33:0] e;
        if (!rst && bvalid && bready) begin
            if (expB.size() == 0) checkOutput("b_unexpected", 1, 0);
            else checkOutput("bresp", bresp, expB.pop_front());
        end
        if (!rst && rvalid && rready) begin
            if (expR.size() == 0) begin
                checkOutput("r_unexpected", 1, 0);
            end else begin
                e = expR.pop_front();
                checkOutput("rdata", rdata, e[31:0]);
                checkOutput("rresp", rresp, e[33:32]);
            end
        end
    end

    task automatic sendWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input bit useAw, input bit useW);
        logic awHs, wHs;
        int   cyc;
        if (useAw) begin
            awaddr  = addr;
            awvalid = 1'b1;
        end
        if (useW) begin
            wdata  = data;
            wstrb  = strb;
            wvalid = 1'b1;
        end
        cyc = 0;
        while ((awvalid || wvalid) && cyc < 50) begin
            @(negedge clk);
            awHs = awvalid && awready;
            wHs  = wvalid && wready;
            @(posedge clk);
            #1;
            if (awHs) awvalid = 1'b0;
            if (wHs) wvalid = 1'b0;
            cyc++;
        end
        if (awvalid || wvalid) begin
            checkOutput("write_handshake_timeout", 0, 1);
            awvalid = 1'b0;
            wvalid  = 1'b0;
        end
    endtask

    task automatic sendRead(input logic [31:0] addr);
        logic [33:0] e;
        logic        hs;
        int          cyc;
        modelRead(addr, e);
        expR.push_back(e);
        araddr  = addr;
        arvalid = 1'b1;
        hs      = 1'b0;
        cyc     = 0;
        while (!hs && cyc < 50) begin
            @(negedge clk);
            hs = arready;
            @(posedge clk);
            #1;
            cyc++;
        end
        arvalid = 1'b0;
        if (!hs) checkOutput("ar_handshake_timeout", 0, 1);
    endtask

    task automatic waitDrain();
        int cyc;
        cyc = 0;
        while ((expB.size() != 0 || expR.size() != 0) && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("drain_pending", 64'(expB.size() + expR.size()), 0);
    endtask

    task automatic fullWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [1:0] resp;
        modelWrite(addr, data, strb, resp);
        expB.push_back(resp);
        sendWrite(addr, data, strb, 1'b1, 1'b1);
    endtask

    task automatic applyStimulus();
        logic [1:0] resp;
        bit         hs;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_handshake_outputs", {awready, wready, bvalid, arready, rvalid}, 0);
        checkOutput("reset_payload", {bresp, rresp, rdata}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Aligned write with AW and W together, then read back
        fullWrite(32'h10, 32'hDEADBEEF, 4'hF);
        checkOutput("b_not_early", bvalid, 0);
        @(posedge clk);
        #1;
        checkOutput("b_latency", bvalid, 1);
        waitDrain();
        sendRead(32'h10);
        checkOutput("r_latency", rvalid, 1);
        waitDrain();

        // W leads AW by three cycles with a single-byte strobe
        sendWrite(32'h0, 32'h0000_00AA, 4'h1, 1'b0, 1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
            checkOutput("b_needs_aw", bvalid, 0);
        end
        modelWrite(32'h10, 32'h0000_00AA, 4'h1, resp);
        expB.push_back(resp);
        sendWrite(32'h10, 32'h0, 4'h0, 1'b1, 1'b0);
        checkOutput("split_b_not_early", bvalid, 0);
        @(posedge clk);
        #1;
        checkOutput("split_b_latency", bvalid, 1);
        waitDrain();
        checkOutput("model_merge", model[4], 32'hDEADBEAA);
        sendRead(32'h10);
        waitDrain();

        // B backpressure
        bready = 1'b0;
        fullWrite(32'h14, 32'h0BAD_F00D, 4'hF);
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            checkOutput("b_hold_valid", bvalid, 1);
            checkOutput("b_hold_resp", bresp, 2'b00);
            @(posedge clk);
            #1;
        end
        checkOutput("b_single_pending", 64'(expB.size()), 1);
        bready = 1'b1;
        waitDrain();

        // R backpressure
        rready = 1'b0;
        sendRead(32'h14);
        for (int k = 0; k < 5; k++) begin
            checkOutput("r_hold_valid", rvalid, 1);
            checkOutput("r_hold_data", rdata, 32'h0BAD_F00D);
            checkOutput("ar_blocked", arready, 0);
            @(posedge clk);
            #1;
        end
        rready = 1'b1;
        waitDrain();

        // Streaming reads, one per cycle
        for (int i = 0; i < 8; i++) fullWrite(32'(i * 4), 32'hC0DE_0000 + 32'(i), 4'hF);
        waitDrain();
        arvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [33:0] e;
            araddr = 32'(i * 4);
            modelRead(araddr, e);
            expR.push_back(e);
            @(negedge clk);
            hs = arready;
            @(posedge clk);
            #1;
            checkOutput("stream_arready", hs, 1);
            checkOutput("stream_rvalid", rvalid, 1);
        end
        arvalid = 1'b0;
        waitDrain();

        // Out-of-range write and read (word 16 in a 16-word RAM)
        fullWrite(32'h40, 32'h1234_5678, 4'hF);
        waitDrain();
        sendRead(32'h40);
        sendRead(32'h0);
        waitDrain();

        // Reset while only AW is buffered
        sendWrite(32'h18, 32'h0, 4'h0, 1'b1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midreset_outputs", {awready, wready, bvalid, arready, rvalid}, 0);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("no_b_after_reset", bvalid, 0);
        end
        sendWrite(32'h0, 32'h5A5A_5A5A, 4'hF, 1'b0, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("dropped_aw_no_commit", bvalid, 0);
        end
        modelWrite(32'h1C, 32'h5A5A_5A5A, 4'hF, resp);
        expB.push_back(resp);
        sendWrite(32'h1C, 32'h0, 4'h0, 1'b1, 1'b0);
        waitDrain();
        sendRead(32'h1C);
        sendRead(32'h18);
        waitDrain();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axil_ram_slave.md
Name: axil_ram_slave

Overview:
- AXI-Lite responder (slave) backed by a word-addressed RAM.
- Terminates the AXI-Lite master port of the AXI-to-AXI-Lite bridge in block and system benches.
- Gives the bridge a deterministic, protocol-correct far end for writes, reads and error responses.
- AW, W, B, AR and R channels are independent. One write and one read are in flight at a time.

Parameters:
ADDR_WIDTH, 32, AXI-Lite address width
AXIL_DATA_WIDTH, 32, data width; must be 32 or 64
AXIL_STRB_WIDTH, AXIL_DATA_WIDTH/8, byte-strobe width
MEM_WORDS_LOG2, 10, log2 of RAM depth in data words
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to RAM size

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-high
s_axil_awaddr  in  ADDR_WIDTH  write address
s_axil_awprot  in  3  accepted, ignored
s_axil_awvalid  in  1  AW valid
s_axil_awready  out  1  AW ready
s_axil_wdata  in  AXIL_DATA_WIDTH  write data
s_axil_wstrb  in  AXIL_STRB_WIDTH  byte enables
s_axil_wvalid  in  1  W valid
s_axil_wready  out  1  W ready
s_axil_bresp  out  2  write response
s_axil_bvalid  out  1  B valid
s_axil_bready  in  1  B ready
s_axil_araddr  in  ADDR_WIDTH  read address
s_axil_arprot  in  3  accepted, ignored
s_axil_arvalid  in  1  AR valid
s_axil_arready  out  1  AR ready
s_axil_rdata  out  AXIL_DATA_WIDTH  read data
s_axil_rresp  out  2  read response
s_axil_rvalid  out  1  R valid
s_axil_rready  in  1  R ready

Behaviour:
- Reset and idle:
  - While rst is high, all ready and valid outputs are 0. bresp, rresp and rdata are 0.
  - aw_full and w_full are cleared on reset. RAM contents are not reset.
  - Reset mid-transaction drops any buffered AW/W and any pending B/R. No response is issued for dropped work.
- Address decode:
  - offset = addr - BASE_ADDR. word = offset >> log2(AXIL_STRB_WIDTH).
  - Sub-word address bits are ignored.
  - An address is in range when addr >= BASE_ADDR and word < 2**MEM_WORDS_LOG2.
- Write path, states WR_IDLE / WR_RESP, with aw_full and w_full one-entry holding registers:
  - awready = !aw_full. wready = !w_full.
  - AW and W are accepted in either order or in the same cycle.
  - Commit happens on the edge where aw_full && w_full in WR_IDLE:
    - RAM bytes with wstrb[i]=1 are written. If wstrb is 0, nothing is written and the response is still OKAY.
    - Both buffers clear, bvalid=1, and the state goes to WR_RESP.
  - bvalid rises one cycle after the later of the AW/W handshakes.
  - bvalid and bresp are held stable until bready. The handshake returns the state to WR_IDLE.
  - Peak throughput: one write per 2 cycles. A new AW/W can be accepted while in WR_RESP, but commit waits for WR_IDLE.
- Read path:
  - arready = !rvalid || rready.
  - On an AR handshake, rdata, rresp and rvalid are registered on the same edge (1-cycle latency).
  - The R payload is held stable while rvalid && !rready.
  - Back-to-back reads with rready tied high sustain 1 read per cycle.
- Same-cycle read and write commit to the same word: read returns the old data (read-before-write).
- bresp/rresp encoding: OKAY=2'b00, SLVERR=2'b10.

Optional Feature:
AXIL_RAM_OOR_ERR_EN
- Defined: out-of-range writes do not modify RAM and return bresp=SLVERR. Out-of-range reads return rdata=0 and rresp=SLVERR.
- Undefined: word index wraps modulo 2**MEM_WORDS_LOG2 and the response is always OKAY.

Decomposition:
- Package axil_ram_pkg:
  - resp_t enum: OKAY, EXOKAY, SLVERR, DECERR.
  - wr_state_t enum: WR_IDLE, WR_RESP.
  - function to compute the word index from an address.
- Sub-module axil_ram_mem: single-clock RAM with one byte-enabled write port and one registered read port. Not reset.
- Handshake logic and decode stay in the top-level block.

Test Plan:
- Aligned write: AW 0x10 and W 0xDEADBEEF (strb 0xF) in the same cycle → bvalid next cycle, bresp=00. Then AR 0x10 → rvalid next cycle, rdata=0xDEADBEEF.
- W-before-AW with partial strobe: W 0x000000AA strb 0x1 at t, AW 0x10 at t+3 → bvalid at t+4. Read 0x10 returns 0xDEADBEAA.
- Backpressure: bready=0 for 5 cycles and rready=0 for 5 cycles → bvalid/rvalid and payloads stay stable, arready=0 while R is stalled. No lost or duplicated responses.
- Streaming reads: 8 ARs to 0x0..0x1C with rready=1 → 8 consecutive rvalid cycles with data in order.
- Out of range, MEM_WORDS_LOG2=4: write 0x40 then read 0x40.
  - With macro: bresp=10, rresp=10, rdata=0, word 0 unchanged.
  - Without macro: word 0 is overwritten, OKAY responses.
- Reset mid-write: AW accepted, then rst pulsed before W → no bvalid after reset. Next full write completes normally.
